// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles every bus signal of the write-back arbiter.
//   s0_*   : execute-stage write request (valid/ready, addr, data)
//   s1_*   : memory-stage write request  (valid/ready, addr, data)
//   we3/a3/wd3 : register-file write port (driven by the arbiter)
//   ra1/ra2    : decode read addresses
//   hz1/hz2    : pending-write hazard flags for ra1/ra2
// Modports: master = requesters/decode side, slave = the arbiter.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          hz1;
  logic          hz2;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output ra1, ra2,
    input  s0_ready, s1_ready,
    input  we3, a3, wd3,
    input  hz1, hz2
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  ra1, ra2,
    output s0_ready, s1_ready,
    output we3, a3, wd3,
    output hz1, hz2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the execute result
// (s0) and the load result (s1). Each source owns a one-entry holding buffer;
// a round-robin grant with an age override for same-address conflicts picks
// the entry written next. Write-port signals are registered.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wb_arbiter_if.slave (requests, write port, hazards)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  // True when a non-zero read address matches a pending write.
  function automatic logic pending_hit(
    input logic [AW-1:0] ra,
    input logic          v0,
    input logic [AW-1:0] a0,
    input logic          v1,
    input logic [AW-1:0] a1,
    input logic          we,
    input logic [AW-1:0] wa
  );
    logic hit;
    hit = (v0 && (a0 == ra)) || (v1 && (a1 == ra)) || (we && (wa == ra));
    return (ra != {AW{1'b0}}) && hit;
  endfunction

  logic          hold_v0_r, hold_v1_r;
  logic [AW-1:0] hold_a0_r, hold_a1_r;
  logic [DW-1:0] hold_d0_r, hold_d1_r;
  logic          rr_r;      // 0: s0 preferred on a two-way grant
  logic          age_r;     // 1: s1 entry is the older one
  logic          we3_r;
  logic [AW-1:0] a3_r;
  logic [DW-1:0] wd3_r;

  logic grant0_s, grant1_s, two_way_s;
  logic load0_s, load1_s, age_nxt_s;

  // Grant selection, derived from buffer state only.
  always_comb begin
    grant0_s  = 1'b0;
    grant1_s  = 1'b0;
    two_way_s = 1'b0;
    if (hold_v0_r && hold_v1_r) begin
      if (hold_a0_r == hold_a1_r) begin
        // Same destination: the older write must land first.
        grant1_s = age_r;
        grant0_s = ~age_r;
      end else begin
        grant0_s  = ~rr_r;
        grant1_s  = rr_r;
        two_way_s = 1'b1;
      end
    end else begin
      grant0_s = hold_v0_r;
      grant1_s = hold_v1_r;
    end
  end

  // Readiness, buffer loads and the age of whatever stays buffered.
  always_comb begin
    bus.s0_ready = rst_n && (!hold_v0_r || grant0_s);
    bus.s1_ready = rst_n && (!hold_v1_r || grant1_s);
    // Register 0 writes are consumed but never buffered.
    load0_s = bus.s0_valid && bus.s0_ready && (bus.s0_addr != {AW{1'b0}});
    load1_s = bus.s1_valid && bus.s1_ready && (bus.s1_addr != {AW{1'b0}});
    age_nxt_s = age_r;
    if (load0_s && load1_s) begin
      age_nxt_s = 1'b1;
    end else if (load0_s && hold_v1_r && !grant1_s) begin
      age_nxt_s = 1'b1;
    end else if (load1_s && hold_v0_r && !grant0_s) begin
      age_nxt_s = 1'b0;
    end else begin
      age_nxt_s = age_r;
    end
  end

  // Hazard flags for decode.
  always_comb begin
    bus.hz1 = pending_hit(bus.ra1, hold_v0_r, hold_a0_r, hold_v1_r, hold_a1_r, we3_r, a3_r);
    bus.hz2 = pending_hit(bus.ra2, hold_v0_r, hold_a0_r, hold_v1_r, hold_a1_r, we3_r, a3_r);
  end

  // Buffers, arbitration state and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v0_r <= 1'b0;
      hold_v1_r <= 1'b0;
      hold_a0_r <= {AW{1'b0}};
      hold_a1_r <= {AW{1'b0}};
      hold_d0_r <= {DW{1'b0}};
      hold_d1_r <= {DW{1'b0}};
      rr_r      <= 1'b0;
      age_r     <= 1'b0;
      we3_r     <= 1'b0;
      a3_r      <= {AW{1'b0}};
      wd3_r     <= {DW{1'b0}};
    end else begin
      // A refill on the grant edge keeps the buffer occupied.
      if (load0_s) begin
        hold_v0_r <= 1'b1;
        hold_a0_r <= bus.s0_addr;
        hold_d0_r <= bus.s0_data;
      end else if (grant0_s) begin
        hold_v0_r <= 1'b0;
      end
      if (load1_s) begin
        hold_v1_r <= 1'b1;
        hold_a1_r <= bus.s1_addr;
        hold_d1_r <= bus.s1_data;
      end else if (grant1_s) begin
        hold_v1_r <= 1'b0;
      end
      if (two_way_s) begin
        rr_r <= ~rr_r;
      end
      age_r <= age_nxt_s;
      we3_r <= grant0_s || grant1_s;
      if (grant1_s) begin
        a3_r  <= hold_a1_r;
        wd3_r <= hold_d1_r;
      end else if (grant0_s) begin
        a3_r  <= hold_a0_r;
        wd3_r <= hold_d0_r;
      end
    end
  end

  assign bus.we3 = we3_r;
  assign bus.a3  = a3_r;
  assign bus.wd3 = wd3_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter: a cycle table covering reset exit,
// single-source streaming, same-address ordering, register-0 writes and
// hazard flags, followed by hand-written contention and mid-write reset runs.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NV = 16;

  logic clk;
  logic rst_n;

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          s0v;
    logic [AW-1:0] s0a;
    logic [DW-1:0] s0d;
    logic          s1v;
    logic [AW-1:0] s1a;
    logic [DW-1:0] s1d;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          r0;
    logic          r1;
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic          h1;
    logic          h2;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  vec_t vecs [NV];
  wr_t  wlog [$];
  wr_t  wexp [$];
  logic mon_en;
  int   total;
  int   bad;

  // Collects every write the port performs while enabled.
  always @(negedge clk) begin
    if (mon_en && bus.we3) begin
      wlog.push_back('{a: bus.a3, d: bus.wd3});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic s0v, input logic [AW-1:0] s0a, input logic [DW-1:0] s0d,
    input logic s1v, input logic [AW-1:0] s1a, input logic [DW-1:0] s1d,
    input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
    input logic r0, input logic r1, input logic we,
    input logic [AW-1:0] a3, input logic [DW-1:0] wd,
    input logic h1, input logic h2
  );
    vec_t v;
    v.s0v = s0v; v.s0a = s0a; v.s0d = s0d;
    v.s1v = s1v; v.s1a = s1a; v.s1d = s1d;
    v.ra1 = ra1; v.ra2 = ra2;
    v.r0 = r0; v.r1 = r1; v.we = we; v.a3 = a3; v.wd = wd; v.h1 = h1; v.h2 = h2;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.s0_valid = 1'b0; bus.s0_addr = 5'd0; bus.s0_data = 32'h0;
    bus.s1_valid = 1'b0; bus.s1_addr = 5'd0; bus.s1_data = 32'h0;
    bus.ra1 = 5'd0; bus.ra2 = 5'd0;
  endtask

  initial begin
    int i0;
    int i1;
    int cyc;
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    idle_inputs();

    // Each row: inputs applied this cycle, outputs expected before the next edge.
    //          s0v  s0a    s0d        s1v  s1a    s1d        ra1    ra2    r0 r1 we a3     wd3        h1 h2
    vecs[0]  = mk(1, 5'd5,  32'hA,     0,   5'd0,  32'h0,     5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,     0, 0);
    vecs[1]  = mk(1, 5'd6,  32'hB,     0,   5'd0,  32'h0,     5'd5,  5'd6,  1, 1, 0, 5'd0,  32'h0,     1, 0);
    vecs[2]  = mk(1, 5'd7,  32'hC,     0,   5'd0,  32'h0,     5'd5,  5'd6,  1, 1, 1, 5'd5,  32'hA,     1, 1);
    vecs[3]  = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd0,  5'd0,  1, 1, 1, 5'd6,  32'hB,     0, 0);
    vecs[4]  = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd7,  5'd0,  1, 1, 1, 5'd7,  32'hC,     1, 0);
    vecs[5]  = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd7,  5'd0,  1, 1, 0, 5'd7,  32'hC,     0, 0);
    vecs[6]  = mk(1, 5'd8,  32'h22,    1,   5'd8,  32'h11,    5'd8,  5'd0,  1, 1, 0, 5'd7,  32'hC,     0, 0);
    vecs[7]  = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd8,  5'd0,  0, 1, 0, 5'd7,  32'hC,     1, 0);
    vecs[8]  = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd8,  5'd0,  1, 1, 1, 5'd8,  32'h11,    1, 0);
    vecs[9]  = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd8,  5'd0,  1, 1, 1, 5'd8,  32'h22,    1, 0);
    vecs[10] = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd8,  5'd0,  1, 1, 0, 5'd8,  32'h22,    0, 0);
    vecs[11] = mk(1, 5'd0,  32'hFF,    0,   5'd0,  32'h0,     5'd0,  5'd0,  1, 1, 0, 5'd8,  32'h22,    0, 0);
    vecs[12] = mk(0, 5'd0,  32'h0,     1,   5'd3,  32'h5,     5'd3,  5'd0,  1, 1, 0, 5'd8,  32'h22,    0, 0);
    vecs[13] = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd3,  5'd0,  1, 1, 0, 5'd8,  32'h22,    1, 0);
    vecs[14] = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd3,  5'd0,  1, 1, 1, 5'd3,  32'h5,     1, 0);
    vecs[15] = mk(0, 5'd0,  32'h0,     0,   5'd0,  32'h0,     5'd3,  5'd0,  1, 1, 0, 5'd3,  32'h5,     0, 0);

    // Reset held for three cycles, outputs checked while held.
    repeat (3) @(negedge clk);
    #1;
    check("rst.s0_ready", 64'(bus.s0_ready), 64'd0);
    check("rst.s1_ready", 64'(bus.s1_ready), 64'd0);
    check("rst.we3", 64'(bus.we3), 64'd0);
    check("rst.a3", 64'(bus.a3), 64'd0);
    check("rst.wd3", 64'(bus.wd3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.s0_valid = vecs[i].s0v; bus.s0_addr = vecs[i].s0a; bus.s0_data = vecs[i].s0d;
      bus.s1_valid = vecs[i].s1v; bus.s1_addr = vecs[i].s1a; bus.s1_data = vecs[i].s1d;
      bus.ra1 = vecs[i].ra1; bus.ra2 = vecs[i].ra2;
      #1;
      check($sformatf("v%0d.s0_ready", i), 64'(bus.s0_ready), 64'(vecs[i].r0));
      check($sformatf("v%0d.s1_ready", i), 64'(bus.s1_ready), 64'(vecs[i].r1));
      check($sformatf("v%0d.we3", i), 64'(bus.we3), 64'(vecs[i].we));
      check($sformatf("v%0d.a3", i), 64'(bus.a3), 64'(vecs[i].a3));
      check($sformatf("v%0d.wd3", i), 64'(bus.wd3), 64'(vecs[i].wd));
      check($sformatf("v%0d.hz1", i), 64'(bus.hz1), 64'(vecs[i].h1));
      check($sformatf("v%0d.hz2", i), 64'(bus.hz2), 64'(vecs[i].h2));
    end

    // Contention: both sources stream four distinct-address writes.
    @(negedge clk);
    idle_inputs();
    wlog.delete();
    wexp.delete();
    for (int k = 0; k < 4; k++) begin
      wexp.push_back('{a: 5'(1 + k), d: 32'h100 + 32'(k)});
      wexp.push_back('{a: 5'(9 + k), d: 32'h200 + 32'(k)});
    end
    mon_en = 1'b1;
    i0 = 0;
    i1 = 0;
    cyc = 0;
    while ((i0 < 4 || i1 < 4) && cyc < 40) begin
      @(negedge clk);
      bus.s0_valid = (i0 < 4); bus.s0_addr = 5'(1 + i0); bus.s0_data = 32'h100 + 32'(i0);
      bus.s1_valid = (i1 < 4); bus.s1_addr = 5'(9 + i1); bus.s1_data = 32'h200 + 32'(i1);
      #1;
      if (cyc >= 1 && cyc <= 6) begin
        check($sformatf("rr.c%0d.s0_ready", cyc), 64'(bus.s0_ready), 64'(cyc % 2));
        check($sformatf("rr.c%0d.s1_ready", cyc), 64'(bus.s1_ready), 64'(1 - (cyc % 2)));
      end
      if (bus.s0_valid && bus.s0_ready) i0++;
      if (bus.s1_valid && bus.s1_ready) i1++;
      cyc++;
    end
    if (cyc >= 40) begin
      check("rr.timeout", 64'(cyc), 64'd0);
    end
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check("rr.write_count", 64'(wlog.size()), 64'(wexp.size()));
    for (int k = 0; k < wexp.size(); k++) begin
      if (k < wlog.size()) begin
        check($sformatf("rr.w%0d.a3", k), 64'(wlog[k].a), 64'(wexp[k].a));
        check($sformatf("rr.w%0d.wd3", k), 64'(wlog[k].d), 64'(wexp[k].d));
      end else begin
        check($sformatf("rr.w%0d.missing", k), 64'(wlog.size()), 64'(k + 1));
      end
    end

    // Mid-operation reset: both buffers occupied and a write on the port.
    @(negedge clk);
    bus.s0_valid = 1'b1; bus.s0_addr = 5'd20; bus.s0_data = 32'hAA;
    bus.s1_valid = 1'b1; bus.s1_addr = 5'd21; bus.s1_data = 32'hBB;
    @(negedge clk);
    bus.s0_valid = 1'b1; bus.s0_addr = 5'd22; bus.s0_data = 32'hCC;
    bus.s1_valid = 1'b1; bus.s1_addr = 5'd23; bus.s1_data = 32'hDD;
    @(negedge clk);
    idle_inputs();
    #1;
    check("mrst.pre_we3", 64'(bus.we3), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst.we3_async", 64'(bus.we3), 64'd0);
    check("mrst.s0_ready", 64'(bus.s0_ready), 64'd0);
    check("mrst.s1_ready", 64'(bus.s1_ready), 64'd0);
    #4;
    rst_n = 1'b1;
    wlog.delete();
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check("mrst.no_writes", 64'(wlog.size()), 64'd0);
    bus.ra1 = 5'd20; bus.ra2 = 5'd23;
    #1;
    check("mrst.hz1", 64'(bus.hz1), 64'd0);
    check("mrst.hz2", 64'(bus.hz2), 64'd0);
    check("mrst.a3", 64'(bus.a3), 64'd0);
    check("mrst.wd3", 64'(bus.wd3), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter that shares the register file's single write port (A3/WD3/WE3) between two requesters: s0 (execute/ALU result) and s1 (memory/load result).
Each source has a one-entry holding buffer and a valid/ready handshake. A round-robin grant, with an age override on same-address conflicts, drives registered write-port signals.
It also exports hazard flags so decode can stall reads of registers whose writes are still pending.

Parameters:
DW, 32, data width of the write port
AW, 5, register address width (2^AW registers; register 0 is hard-wired zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s0_valid  in  1  source 0 write request
s0_ready  out  1  source 0 can accept this cycle
s0_addr  in  AW  source 0 destination register
s0_data  in  DW  source 0 write data
s1_valid  in  1  source 1 write request
s1_ready  out  1  source 1 can accept this cycle
s1_addr  in  AW  source 1 destination register
s1_data  in  DW  source 1 write data
we3  out  1  register-file write enable (registered)
a3  out  AW  register-file write address (registered)
wd3  out  DW  register-file write data (registered)
ra1  in  AW  read address 1 being decoded
ra2  in  AW  read address 2 being decoded
hz1  out  1  ra1 has a pending write
hz2  out  1  ra2 has a pending write

Behaviour:
- Reset (async, rst_n=0): hold_v0=hold_v1=0; we3=0, a3=0, wd3=0; rr pointer=0 (s0 preferred); age flag cleared. s0_ready=s1_ready=0 while rst_n=0.
- Per-source buffer state: hold_vN, hold_aN, hold_dN.
- Handshake: transfer when sN_valid & sN_ready at a rising edge. Data/addr are sampled on that edge. Valid may drop without a transfer; no stability requirement on the requester.
- sN_ready = rst_n & (!hold_vN | grantN). grantN is computed from buffer state only, with no combinational path from sN_valid. One write per cycle per source is sustainable when uncontended.
- Addr 0: a transfer with sN_addr==0 is accepted normally, never buffered, and never produces we3.
- Grant (combinational, from buffers):
  - Only one buffer valid: grant it.
  - Both valid, addresses differ: grant the source not granted last (rr pointer). The pointer toggles to the other source after every two-way grant; single-source grants leave the pointer unchanged.
  - Both valid, addresses equal: grant the older entry (age flag). If both were buffered on the same edge, grant s1 (older pipeline stage). The pointer is not updated.
- Output register: on each edge, we3 <= any grant; a3/wd3 <= the granted entry's addr/data. When there is no grant, we3=0 and a3/wd3 hold their previous values. The granted buffer clears unless refilled on the same edge (simultaneous grant + accept: the buffer takes the new entry, hold_v stays 1).
- Latency: accept at edge k; we3/a3/wd3 valid after edge k+1; register file written at edge k+2. Uncontended throughput is 1 write/cycle. Under contention each source gets at least one of every two write slots.
- Hazard flags (combinational): hzN = (raN != 0) & ((hold_v0 & hold_a0==raN) | (hold_v1 & hold_a1==raN) | (we3 & a3==raN)).
- Reset mid-operation: buffered and in-flight writes are dropped, with no partial write. we3 falls asynchronously with rst_n.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, then high -> we3=0, a3=0, wd3=0, hz1=hz2=0; s0_ready=s1_ready=1 after release.
2. Single source streaming: s0 sends (r5,0xA), (r6,0xB), (r7,0xC) on consecutive cycles -> we3=1 for 3 consecutive cycles starting 2 edges after first accept, with a3=5,6,7 in order; s0_ready never drops.
3. Contention round-robin: s0 and s1 hold valid for 4 cycles with distinct addresses (s0: r1..r4, s1: r9..r12) -> writes alternate s0,s1,s0,s1… starting with s0; each ready deasserts on every other cycle; no write lost.
4. Same-address ordering: s1 (r8,0x11) and s0 (r8,0x22) accepted on the same edge -> a3=8 with wd3=0x11, then wd3=0x22; final register value 0x22.
5. Addr-0 and hazards: s0 sends (r0,0xFF) -> ready=1 and no we3. Then s1 sends (r3,0x5) with ra1=3, ra2=0 -> hz1=1 from accept until the cycle after we3 pulses; hz2=0 throughout.
6. Mid-operation reset: both buffers full and we3=1, then rst_n pulsed low for half a cycle -> we3 drops immediately; no write to either buffered address occurs after release.
